aes_req_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one AES core between NREQ requesters.
- Grants one requester at a time and streams its 128-bit text/key into the 32-bit-wide AES input buffer as four beats.
- Waits for the core's done, then returns completion or timeout status to the granted requester before re-arbitrating.
- Sits between the host-side requester ports and the aes input buffer / core.

---
 rtl/aes_req_arbiter.sv | 159 +++++++++++++++
 tb/tb_aes_req_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES core between NREQ requesters: streams the
// winner's text/key as four 32-bit beats, then returns done or timeout status.
module aes_req_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_i,
    input  logic [NREQ*32-1:0] text_i,
    input  logic [NREQ*32-1:0] key_i,
    output logic [NREQ-1:0]    gnt_o,
    output logic               word_rd_o,
    output logic [1:0]         word_idx_o,
    output logic               busy_o,
    output logic               buf_ld_o,
    output logic [31:0]        buf_text_o,
    output logic [31:0]        buf_key_o,
    input  logic               done_i,
    output logic [NREQ-1:0]    done_o,
    output logic [NREQ-1:0]    err_o
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   gidx_q, gidx_d;
    logic [1:0]      beat_q, beat_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREQ-1:0] err_q, err_d;
    logic            word_rd_q, word_rd_d;
    logic [1:0]      word_idx_q, word_idx_d;
    logic            buf_ld_q, buf_ld_d;
    logic            busy_q, busy_d;

    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [IW-1:0]   cand;

    // Search starts just after the last served requester, so it drops to lowest priority.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr_q) + 1 + i) % NREQ);
            if (!sel_found && req_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = LOAD;
                    gidx_d  = sel_idx;
                    beat_d  = 2'd0;
                end
            end
            LOAD: begin
                if (beat_q == 2'd3) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_d = DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
                ptr_d   = gidx_q;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they appear registered.
        gnt_d  = '0;
        done_d = '0;
        err_d  = '0;
        if (state_d != IDLE) gnt_d[gidx_d] = 1'b1;
        if (state_d == DONE) done_d[gidx_d] = 1'b1;
        if (state_d == ERR)  err_d[gidx_d] = 1'b1;
        word_rd_d  = (state_d == LOAD);
        word_idx_d = (state_d == LOAD) ? beat_d : 2'd0;
        buf_ld_d   = (state_d == LOAD) && (beat_d == 2'd0);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NREQ - 1);
            gidx_q     <= '0;
            beat_q     <= 2'd0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            word_rd_q  <= 1'b0;
            word_idx_q <= 2'd0;
            buf_ld_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            word_rd_q  <= word_rd_d;
            word_idx_q <= word_idx_d;
            buf_ld_q   <= buf_ld_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        buf_text_o = '0;
        buf_key_o  = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (word_rd_q && gidx_q == IW'(n)) begin
                buf_text_o = text_i[n*32 +: 32];
                buf_key_o  = key_i[n*32 +: 32];
            end
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign word_rd_o  = word_rd_q;
    assign word_idx_o = word_idx_q;
    assign buf_ld_o   = buf_ld_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Randomized bench for aes_req_arbiter, checked every cycle against a
// transaction-level model (owner + age within the transaction).
module tb_aes_req_arbiter;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_i;
    logic [NREQ*32-1:0] text_i;
    logic [NREQ*32-1:0] key_i;
    logic               done_i;
    logic [NREQ-1:0]    gnt_o;
    logic               word_rd_o;
    logic [1:0]         word_idx_o;
    logic               busy_o;
    logic               buf_ld_o;
    logic [31:0]        buf_text_o;
    logic [31:0]        buf_key_o;
    logic [NREQ-1:0]    done_o;
    logic [NREQ-1:0]    err_o;

    aes_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .text_i(text_i), .key_i(key_i),
        .gnt_o(gnt_o), .word_rd_o(word_rd_o), .word_idx_o(word_idx_o),
        .busy_o(busy_o), .buf_ld_o(buf_ld_o), .buf_text_o(buf_text_o),
        .buf_key_o(buf_key_o), .done_i(done_i), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    // Model: a transaction is an owner plus its age in cycles since beat 0;
    // end_kind marks the single status cycle (1 = done, 2 = timeout).
    bit          m_active = 1'b0;
    int          m_owner  = 0;
    int          m_age    = 0;
    int          m_end    = 0;
    int          m_last   = NREQ - 1;
    logic [31:0] txt_w [NREQ][4];
    logic [31:0] key_w [NREQ][4];
    bit          fix0 = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelStep(input logic rst_v, input logic [NREQ-1:0] req_v, input logic done_v);
        if (!rst_v) begin
            m_active = 1'b0;
            m_end    = 0;
            m_age    = 0;
            m_last   = NREQ - 1;
        end else if (!m_active) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req_v[c]) begin
                    m_active = 1'b1;
                    m_owner  = c;
                    m_age    = 0;
                    m_end    = 0;
                    break;
                end
            end
        end else if (m_end != 0) begin
            m_active = 1'b0;
            m_last   = m_owner;
            m_end    = 0;
        end else if (m_age >= 4 && done_v) begin
            m_end = 1;
        end else if (m_age >= 4 && (m_age - 4) == TIMEOUT - 1) begin
            m_end = 2;
        end else begin
            m_age++;
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [NREQ-1:0] req_v, input logic done_v);
        logic [NREQ*32-1:0] tv, kv;
        logic [NREQ-1:0]    eg, ed, ee;
        logic               erd;
        logic [31:0]        etxt, ekey;
        int                 beat;
        rst    = rst_v;
        req_i  = req_v;
        done_i = done_v;
        @(posedge clk);
        modelStep(rst_v, req_v, done_v);
        #1;
        // Requesters present the word for the current beat of their transaction.
        erd = m_active && m_end == 0 && m_age < 4;
        tv  = '0;
        kv  = '0;
        for (int n = 0; n < NREQ; n++) begin
            if (!(m_active && m_owner == n) && !(fix0 && n == 0)) begin
                for (int w = 0; w < 4; w++) begin
                    txt_w[n][w] = $urandom;
                    key_w[n][w] = $urandom;
                end
            end
            beat = (erd && m_owner == n) ? m_age : 0;
            tv[n*32 +: 32] = txt_w[n][beat];
            kv[n*32 +: 32] = key_w[n][beat];
        end
        text_i = tv;
        key_i  = kv;
        eg = '0;
        ed = '0;
        ee = '0;
        if (m_active) eg[m_owner] = 1'b1;
        if (m_active && m_end == 1) ed[m_owner] = 1'b1;
        if (m_active && m_end == 2) ee[m_owner] = 1'b1;
        etxt = erd ? txt_w[m_owner][m_age] : 32'h0;
        ekey = erd ? key_w[m_owner][m_age] : 32'h0;
        #1;
        checkOutput("gnt",      32'(gnt_o),      32'(eg));
        checkOutput("busy",     32'(busy_o),     32'(m_active));
        checkOutput("word_rd",  32'(word_rd_o),  32'(erd));
        checkOutput("word_idx", 32'(word_idx_o), erd ? 32'(m_age) : 32'h0);
        checkOutput("buf_ld",   32'(buf_ld_o),   32'(erd && m_age == 0));
        checkOutput("buf_text", buf_text_o,      etxt);
        checkOutput("buf_key",  buf_key_o,       ekey);
        checkOutput("done",     32'(done_o),     32'(ed));
        checkOutput("err",      32'(err_o),      32'(ee));
    endtask

    // One transaction: ages are counted from beat 0; -1 disables that event.
    task automatic runTxn(input logic [NREQ-1:0] req_first, input logic [NREQ-1:0] req_rest,
                          input int done_age, input int stray_age, input int rst_age,
                          output logic [31:0] got_gnt);
        bit started;
        logic rv, dv;
        started = 1'b0;
        got_gnt = '0;
        for (int c = 0; c < 40; c++) begin
            dv = m_active && m_end == 0 && (m_age == done_age || m_age == stray_age);
            rv = !(m_active && m_end == 0 && m_age == rst_age);
            applyStimulus(rv, (c == 0) ? req_first : req_rest, dv);
            if (buf_ld_o) got_gnt = 32'(gnt_o);
            if (m_active) started = 1'b1;
            if (started && !m_active) break;
        end
    endtask

    initial begin
        logic [31:0] g;
        int          sched;
        logic        rv, dv;
        rst    = 1'b0;
        req_i  = '0;
        done_i = 1'b0;
        text_i = '0;
        key_i  = '0;
        for (int n = 0; n < NREQ; n++)
            for (int w = 0; w < 4; w++) begin
                txt_w[n][w] = $urandom;
                key_w[n][w] = $urandom;
            end

        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '1, 1'b1);

        fix0 = 1'b1;
        txt_w[0][0] = 32'h00112233; txt_w[0][1] = 32'h44556677;
        txt_w[0][2] = 32'h8899AABB; txt_w[0][3] = 32'hCCDDEEFF;
        key_w[0][0] = 32'h0F0E0D0C; key_w[0][1] = 32'h0B0A0908;
        key_w[0][2] = 32'h07060504; key_w[0][3] = 32'h03020100;
        runTxn(2'b01, 2'b00, 10, -1, -1, g);
        checkOutput("single_gnt", g, 32'h1);
        fix0 = 1'b0;

        applyStimulus(1'b0, '0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            runTxn(2'b11, 2'b11, 5, -1, -1, g);
            checkOutput("fair_gnt", g, (t % 2 == 0) ? 32'h1 : 32'h2);
        end

        runTxn(2'b10, 2'b00, -1, -1, -1, g);
        checkOutput("timeout_gnt", g, 32'h2);
        runTxn(2'b11, 2'b00, 5, -1, -1, g);
        checkOutput("after_timeout_gnt", g, 32'h1);

        runTxn(2'b01, 2'b00, 4 + TIMEOUT - 1, -1, -1, g);
        runTxn(2'b01, 2'b00, 7, 1, -1, g);

        runTxn(2'b11, 2'b11, -1, -1, 6, g);
        runTxn(2'b11, 2'b11, 5, -1, -1, g);
        checkOutput("after_reset_gnt", g, 32'h1);

        sched = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!m_active)
                sched = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, TIMEOUT + 3));
            if (m_active && m_end == 0 && m_age >= 4)
                dv = ((m_age - 4) == sched);
            else
                dv = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 99) != 0);
            applyStimulus(rv, NREQ'($urandom), dv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
